// File: rtl/time_of_day_tracker.sv
// rtl/time_of_day_tracker.sv - hour-of-day counter with programmable day/night window decode
// Counts hours from a tick strobe and flags day/night plus day-change, midnight and error events.
module time_of_day_tracker #(
  parameter int TICKS_PER_HOUR = 3600,
  parameter int HOUR_W         = 5,
  parameter int TICK_W         = 12,
  parameter int DAY_START_RST  = 6,
  parameter int DAY_END_RST    = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tickIn,
  input  logic              loadEn,
  input  logic [HOUR_W-1:0] loadHour,
  input  logic              cfgEn,
  input  logic [HOUR_W-1:0] cfgDayStart,
  input  logic [HOUR_W-1:0] cfgDayEnd,
  output logic [HOUR_W-1:0] hourOut,
  output logic              isDayOut,
  output logic              dayChangeOut,
  output logic              midnightOut,
  output logic              errOut
);

  localparam logic [HOUR_W-1:0] MAX_HOUR  = HOUR_W'(23);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(TICKS_PER_HOUR - 1);

  logic [HOUR_W-1:0] r_hour;
  logic [TICK_W-1:0] r_sub;
  logic [HOUR_W-1:0] r_day_start;
  logic [HOUR_W-1:0] r_day_end;
  logic              r_is_day;
  logic              r_day_change;
  logic              r_midnight;
  logic              r_err;

  logic              w_load_ok;
  logic              w_load_bad;
  logic              w_cfg_ok;
  logic              w_cfg_bad;
  logic              w_count;
  logic              w_hour_done;
  logic              w_midnight;
  logic              w_day_dec;
  logic [HOUR_W-1:0] w_hour_nxt;
  logic [TICK_W-1:0] w_sub_nxt;

  assign w_load_ok   = loadEn && (loadHour <= MAX_HOUR);
  assign w_load_bad  = loadEn && (loadHour > MAX_HOUR);
  assign w_cfg_ok    = cfgEn && (cfgDayStart <= MAX_HOUR) && (cfgDayEnd <= MAX_HOUR);
  assign w_cfg_bad   = cfgEn && !w_cfg_ok;
  // A rejected load leaves the tick path untouched, so only a valid load swallows the tick.
  assign w_count     = tickIn && !w_load_ok;
  assign w_hour_done = w_count && (r_sub == LAST_TICK);
  assign w_midnight  = w_hour_done && (r_hour == MAX_HOUR);

  always_comb begin
    w_hour_nxt = r_hour;
    w_sub_nxt  = r_sub;
    if (w_load_ok) begin
      w_hour_nxt = loadHour;
      w_sub_nxt  = '0;
    end else if (w_count) begin
      if (w_hour_done) begin
        w_sub_nxt  = '0;
        w_hour_nxt = (r_hour == MAX_HOUR) ? '0 : r_hour + HOUR_W'(1);
      end else begin
        w_sub_nxt  = r_sub + TICK_W'(1);
      end
    end
  end

  always_comb begin
    w_day_dec = 1'b0;
    if (r_day_start < r_day_end) begin
      w_day_dec = (r_hour >= r_day_start) && (r_hour < r_day_end);
    end else if (r_day_start > r_day_end) begin
      w_day_dec = (r_hour >= r_day_start) || (r_hour < r_day_end);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hour       <= '0;
      r_sub        <= '0;
      r_day_start  <= HOUR_W'(DAY_START_RST);
      r_day_end    <= HOUR_W'(DAY_END_RST);
      r_is_day     <= 1'b0;
      r_day_change <= 1'b0;
      r_midnight   <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_hour       <= w_hour_nxt;
      r_sub        <= w_sub_nxt;
      if (w_cfg_ok) begin
        r_day_start <= cfgDayStart;
        r_day_end   <= cfgDayEnd;
      end
      r_is_day     <= w_day_dec;
      r_day_change <= (w_day_dec != r_is_day);
      r_midnight   <= w_midnight;
      r_err        <= w_load_bad || w_cfg_bad;
    end
  end

  assign hourOut      = r_hour;
  assign isDayOut     = r_is_day;
  assign dayChangeOut = r_day_change;
  assign midnightOut  = r_midnight;
  assign errOut       = r_err;

endmodule

// File: tb/tb_time_of_day_tracker.sv
// tb/tb_time_of_day_tracker.sv - directed self-checking bench for time_of_day_tracker
// Four ticks per hour keep the hour sweeps short.
module tb_time_of_day_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tickIn;
  logic       loadEn;
  logic [4:0] loadHour;
  logic       cfgEn;
  logic [4:0] cfgDayStart;
  logic [4:0] cfgDayEnd;
  logic [4:0] hourOut;
  logic       isDayOut;
  logic       dayChangeOut;
  logic       midnightOut;
  logic       errOut;

  int n_tests = 0;
  int n_fail  = 0;

  time_of_day_tracker #(
    .TICKS_PER_HOUR(4),
    .HOUR_W(5),
    .TICK_W(12),
    .DAY_START_RST(6),
    .DAY_END_RST(20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tickIn(tickIn),
    .loadEn(loadEn),
    .loadHour(loadHour),
    .cfgEn(cfgEn),
    .cfgDayStart(cfgDayStart),
    .cfgDayEnd(cfgDayEnd),
    .hourOut(hourOut),
    .isDayOut(isDayOut),
    .dayChangeOut(dayChangeOut),
    .midnightOut(midnightOut),
    .errOut(errOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic t, input logic ld, input logic [4:0] lh,
                      input logic cf, input logic [4:0] cs, input logic [4:0] ce);
    tickIn = t; loadEn = ld; loadHour = lh;
    cfgEn = cf; cfgDayStart = cs; cfgDayEnd = ce;
    @(posedge clk);
    #1;
    tickIn = 1'b0; loadEn = 1'b0; cfgEn = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
  endtask

  task automatic tick();
    step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
  endtask

  task automatic load(input logic [4:0] h);
    step(1'b0, 1'b1, h, 1'b0, 5'd0, 5'd0);
  endtask

  task automatic cfg(input logic [4:0] s, input logic [4:0] e);
    step(1'b0, 1'b0, 5'd0, 1'b1, s, e);
  endtask

  initial begin
    rst_n = 1'b0;
    tickIn = 1'b0; loadEn = 1'b0; loadHour = '0;
    cfgEn = 1'b0; cfgDayStart = '0; cfgDayEnd = '0;
    idle();
    idle();
    rst_n = 1'b1;

    chk("rst_hour", hourOut, 0);
    chk("rst_isday", isDayOut, 0);
    chk("rst_daychg", dayChangeOut, 0);
    chk("rst_midnight", midnightOut, 0);
    chk("rst_err", errOut, 0);

    // 1: 24 ticks reach 06:00, day flag follows one cycle later
    for (int i = 0; i < 23; i++) tick();
    chk("t1_hour_after23", hourOut, 5);
    tick();
    chk("t1_hour_after24", hourOut, 6);
    chk("t1_isday_lag", isDayOut, 0);
    idle();
    chk("t1_isday", isDayOut, 1);
    chk("t1_daychg", dayChangeOut, 1);
    idle();
    chk("t1_daychg_clear", dayChangeOut, 0);

    // 2: midnight rollover by ticking; loading 0 does not pulse midnight
    load(5'd23);
    chk("t2_load23", hourOut, 23);
    for (int i = 0; i < 3; i++) tick();
    chk("t2_hour_pre", hourOut, 23);
    chk("t2_mid_pre", midnightOut, 0);
    tick();
    chk("t2_hour_wrap", hourOut, 0);
    chk("t2_midnight", midnightOut, 1);
    idle();
    chk("t2_mid_clear", midnightOut, 0);
    load(5'd0);
    chk("t2_load0_hour", hourOut, 0);
    chk("t2_load0_mid", midnightOut, 0);

    // 3: wrapping window 22/5, then empty window 7/7
    cfg(5'd22, 5'd5);
    load(5'd23);
    idle();
    chk("t3_h23_day", isDayOut, 1);
    idle();
    load(5'd5);
    idle();
    chk("t3_h5_night", isDayOut, 0);
    chk("t3_h5_chg", dayChangeOut, 1);
    load(5'd4);
    idle();
    chk("t3_h4_day", isDayOut, 1);
    cfg(5'd7, 5'd7);
    for (int h = 0; h < 24; h++) begin
      load(5'(h));
      idle();
      chk($sformatf("t3_empty_h%0d", h), isDayOut, 0);
    end

    // 4: rejected load with coincident tick still counts; rejected cfg keeps window
    cfg(5'd22, 5'd5);
    load(5'd9);
    for (int i = 0; i < 3; i++) tick();
    chk("t4_pre_hour", hourOut, 9);
    step(1'b1, 1'b1, 5'd30, 1'b0, 5'd0, 5'd0);
    chk("t4_err", errOut, 1);
    chk("t4_hour", hourOut, 10);
    for (int i = 0; i < 3; i++) tick();
    chk("t4_err_clear", errOut, 0);
    chk("t4_sub0_hour", hourOut, 10);
    tick();
    chk("t4_next_hour", hourOut, 11);
    cfg(5'd25, 5'd5);
    chk("t4_cfg_err", errOut, 1);
    load(5'd23);
    idle();
    chk("t4_win_h23", isDayOut, 1);
    load(5'd12);
    idle();
    chk("t4_win_h12", isDayOut, 0);
    step(1'b0, 1'b1, 5'd31, 1'b1, 5'd3, 5'd24);
    chk("t4_dual_err", errOut, 1);
    chk("t4_dual_hour", hourOut, 12);
    idle();
    chk("t4_dual_err_once", errOut, 0);

    // 5: valid load discards a coincident tick and clears the sub-hour count
    load(5'd11);
    tick();
    tick();
    step(1'b1, 1'b1, 5'd12, 1'b0, 5'd0, 5'd0);
    chk("t5_hour", hourOut, 12);
    for (int i = 0; i < 3; i++) tick();
    chk("t5_hour_hold", hourOut, 12);
    tick();
    chk("t5_hour_next", hourOut, 13);

    // 6: reset mid-count restores hour and window
    load(5'd15);
    tick();
    tick();
    chk("t6_pre_hour", hourOut, 15);
    rst_n = 1'b0;
    step(1'b1, 1'b1, 5'd7, 1'b1, 5'd1, 5'd2);
    rst_n = 1'b1;
    chk("t6_hour", hourOut, 0);
    chk("t6_isday", isDayOut, 0);
    chk("t6_daychg", dayChangeOut, 0);
    chk("t6_err", errOut, 0);
    idle();
    chk("t6_isday_after", isDayOut, 0);
    chk("t6_daychg_after", dayChangeOut, 0);
    load(5'd6);
    idle();
    chk("t6_win_h6", isDayOut, 1);
    load(5'd20);
    idle();
    chk("t6_win_h20", isDayOut, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
